control_sequencer: RTL and testbench

Control unit paired with the datapath top level (ALU datapath, data memory, PC/branch logic, instruction memory, instruction register). It consumes the instruction-register opcode and an R-zero flag. It produces the datapath's load, increment and select strobes (HLT, INC, REPC, REIR, REDMEM, RER, cu_A, cu_B) through a fixed five-state fetch/decode/execute sequence, plus a halt/idle sequencer and a retired-instruction counter.

---
 rtl/control_sequencer.sv | 133 +++++++++++++
 tb/tb_control_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Control unit for the accumulator datapath: a fixed fetch/decode/execute
// sequence that drives load/increment/select strobes, plus halt handling and a retired-instruction counter.
module control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_cu,
    input  logic             start,
    input  logic [3:0]       ir_opcode,
    input  logic             r_zero,
    output logic             HLT,
    output logic             INC,
    output logic             REPC,
    output logic             REIR,
    output logic             REDMEM,
    output logic             RER,
    output logic [1:0]       cu_A,
    output logic [1:0]       cu_B,
    output logic [2:0]       seq_state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] OP_HLT   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_LDI   = 4'd7;
    localparam logic [3:0] OP_JMP   = 4'd8;
    localparam logic [3:0] OP_JZ    = 4'd9;

    localparam logic [1:0] SEL_R    = 2'b00;
    localparam logic [1:0] SEL_DMEM = 2'b01;
    localparam logic [1:0] SEL_OPND = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOADIR = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_NEXTPC = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t state, state_next;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_cu) begin
        if (!reset_cu) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each pass through NEXTPC retires exactly one instruction, including a resumed HLT.
    always_ff @(posedge clk or negedge reset_cu) begin
        if (!reset_cu) begin
            count_q <= '0;
        end else if (state == S_NEXTPC) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = start ? S_FETCH : S_IDLE;
            S_FETCH:  state_next = S_LOADIR;
            S_LOADIR: state_next = S_DECODE;
            S_DECODE: state_next = (ir_opcode == OP_HLT) ? S_HALT : S_EXEC;
            S_EXEC:   state_next = S_NEXTPC;
            S_NEXTPC: state_next = S_FETCH;
            S_HALT:   state_next = start ? S_NEXTPC : S_HALT;
            S_BAD:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Strobes depend only on registered state and the datapath status, never on start.
    always_comb begin
        HLT    = 1'b0;
        INC    = 1'b0;
        REPC   = 1'b0;
        REIR   = 1'b0;
        REDMEM = 1'b0;
        RER    = 1'b0;
        cu_A   = SEL_R;
        cu_B   = SEL_R;
        case (state)
            S_LOADIR: REIR = 1'b1;
            S_EXEC: begin
                case (ir_opcode)
                    OP_LOAD: begin
                        RER  = 1'b1;
                        cu_A = SEL_ZERO;
                        cu_B = SEL_DMEM;
                    end
                    OP_LDI: begin
                        RER  = 1'b1;
                        cu_A = SEL_ZERO;
                        cu_B = SEL_OPND;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        RER  = 1'b1;
                        cu_A = SEL_R;
                        cu_B = SEL_DMEM;
                    end
                    OP_STORE: REDMEM = 1'b1;
                    default: ;
                endcase
            end
            S_NEXTPC: begin
                if (ir_opcode == OP_JMP || (ir_opcode == OP_JZ && r_zero)) begin
                    REPC = 1'b1;
                end else begin
                    INC = 1'b1;
                end
            end
            S_HALT: HLT = 1'b1;
            default: ;
        endcase
    end

    assign seq_state   = state;
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer; expected cycles come from
// per-instruction rules kept here, and a narrow-counter instance checks wraparound.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_cu;
    logic        start;
    logic [3:0]  ir_opcode;
    logic        r_zero;

    logic        HLT, INC, REPC, REIR, REDMEM, RER;
    logic [1:0]  cu_A, cu_B;
    logic [2:0]  seq_state;
    logic [15:0] instr_count;

    logic        s_HLT, s_INC, s_REPC, s_REIR, s_REDMEM, s_RER;
    logic [1:0]  s_cu_A, s_cu_B;
    logic [2:0]  s_seq_state;
    logic [1:0]  s_instr_count;

    int total = 0;
    int bad = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    control_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .reset_cu(reset_cu), .start(start), .ir_opcode(ir_opcode), .r_zero(r_zero),
        .HLT(HLT), .INC(INC), .REPC(REPC), .REIR(REIR), .REDMEM(REDMEM), .RER(RER),
        .cu_A(cu_A), .cu_B(cu_B), .seq_state(seq_state), .instr_count(instr_count)
    );

    // A 2-bit counter wraps every four retirements, exercising all-ones -> 0 often.
    control_sequencer #(.CNT_W(2)) dut_small (
        .clk(clk), .reset_cu(reset_cu), .start(start), .ir_opcode(ir_opcode), .r_zero(r_zero),
        .HLT(s_HLT), .INC(s_INC), .REPC(s_REPC), .REIR(s_REIR), .REDMEM(s_REDMEM), .RER(s_RER),
        .cu_A(s_cu_A), .cu_B(s_cu_B), .seq_state(s_seq_state), .instr_count(s_instr_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe vector order: {HLT, INC, REPC, REIR, REDMEM, RER}
    task automatic check(input string tag, input logic [2:0] st, input logic [5:0] sb,
                         input logic [1:0] a, input logic [1:0] b);
        logic [5:0]  obs_sb;
        logic [15:0] exp_cnt;
        logic [1:0]  exp_small;
        obs_sb    = {HLT, INC, REPC, REIR, REDMEM, RER};
        exp_cnt   = 16'(model_count);
        exp_small = 2'(model_count);
        total++;
        assert (seq_state === st) else begin
            bad++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, seq_state, st);
        end
        total++;
        assert (obs_sb === sb) else begin
            bad++;
            $error("FAIL %s strobes: observed=%b expected=%b", tag, obs_sb, sb);
        end
        total++;
        assert ({cu_A, cu_B} === {a, b}) else begin
            bad++;
            $error("FAIL %s cu_A/cu_B: observed=%b/%b expected=%b/%b", tag, cu_A, cu_B, a, b);
        end
        total++;
        assert (instr_count === exp_cnt) else begin
            bad++;
            $error("FAIL %s instr_count: observed=%h expected=%h", tag, instr_count, exp_cnt);
        end
        total++;
        assert (s_instr_count === exp_small) else begin
            bad++;
            $error("FAIL %s small_count: observed=%0d expected=%0d", tag, s_instr_count, exp_small);
        end
    endtask

    // EXEC behaviour from the opcode table: returns strobes and ALU selects.
    task automatic exec_expect(input logic [3:0] op, output logic [5:0] sb,
                               output logic [1:0] a, output logic [1:0] b);
        sb = 6'b0; a = 2'b00; b = 2'b00;
        if (op == 4'd1)                      begin sb = 6'b000001; a = 2'b11; b = 2'b01; end
        else if (op == 4'd7)                 begin sb = 6'b000001; a = 2'b11; b = 2'b10; end
        else if (op >= 4'd3 && op <= 4'd6)   begin sb = 6'b000001; a = 2'b00; b = 2'b01; end
        else if (op == 4'd2)                 sb = 6'b000010;
    endtask

    function automatic logic [5:0] nextpc_expect(input logic [3:0] op, input logic rz);
        return (op == 4'd8 || (op == 4'd9 && rz)) ? 6'b001000 : 6'b010000;
    endfunction

    // Expects the next rising edge to enter FETCH.
    task automatic run_instr(input logic [3:0] op, input logic rz, input int halt_cycles);
        logic [5:0] sb;
        logic [1:0] a, b;
        ir_opcode = op;
        r_zero    = rz;
        step(); check("fetch", 3'd1, 6'b0, 2'b00, 2'b00);
        start = 1'b0;
        step(); check("loadir", 3'd2, 6'b000100, 2'b00, 2'b00);
        step(); check("decode", 3'd3, 6'b0, 2'b00, 2'b00);
        if (op == 4'd0) begin
            for (int i = 0; i < halt_cycles; i++) begin
                step(); check("halt", 3'd6, 6'b100000, 2'b00, 2'b00);
            end
            start = 1'b1;
            step(); check("resume", 3'd5, 6'b010000, 2'b00, 2'b00);
            model_count++;
        end else begin
            exec_expect(op, sb, a, b);
            step(); check("exec", 3'd4, sb, a, b);
            step(); check("nextpc", 3'd5, nextpc_expect(op, rz), 2'b00, 2'b00);
            model_count++;
        end
    endtask

    initial begin
        reset_cu  = 1'b0;
        start     = 1'b0;
        ir_opcode = 4'd0;
        r_zero    = 1'b0;
        step();
        step(); check("reset", 3'd0, 6'b0, 2'b00, 2'b00);
        @(negedge clk);
        reset_cu = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("idle", 3'd0, 6'b0, 2'b00, 2'b00);
        end

        start = 1'b1;
        run_instr(4'd3, 1'b0, 0);
        run_instr(4'd3, 1'b1, 0);
        run_instr(4'd2, 1'b0, 0);
        run_instr(4'd7, 1'b0, 0);
        run_instr(4'd1, 1'b0, 0);
        run_instr(4'd9, 1'b1, 0);
        run_instr(4'd9, 1'b0, 0);
        run_instr(4'd8, 1'b0, 0);
        run_instr(4'd8, 1'b1, 0);
        run_instr(4'd12, 1'b1, 0);
        run_instr(4'd0, 1'b0, 20);
        // start stays high through the resume: the next HLT must still be decoded afresh
        run_instr(4'd4, 1'b0, 0);
        run_instr(4'd0, 1'b1, 3);
        start = 1'b0;

        // Abort in the middle of an ADD
        ir_opcode = 4'd3;
        step(); check("abort_fetch", 3'd1, 6'b0, 2'b00, 2'b00);
        step(); check("abort_loadir", 3'd2, 6'b000100, 2'b00, 2'b00);
        step(); check("abort_decode", 3'd3, 6'b0, 2'b00, 2'b00);
        step(); check("abort_exec", 3'd4, 6'b000001, 2'b00, 2'b01);
        #2 reset_cu = 1'b0;
        model_count = 0;
        #1 check("abort_reset", 3'd0, 6'b0, 2'b00, 2'b00);
        @(negedge clk);
        reset_cu = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); check("post_abort_idle", 3'd0, 6'b0, 2'b00, 2'b00);
        end

        start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            run_instr(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(4, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
